// File: rtl/fan_pwm_ramp_ctrl.sv
// fan_pwm_ramp_ctrl
//   Multi-level fan speed controller with soft-start/soft-stop duty ramping
//   and an internal PWM generator.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   step       pulse: advance one level (ring wrap back to idle)
//   load       pulse: load level_in (clamped to LEVELS-1), wins over step
//   level_in   requested level for load
//   set_idle   level-sensitive: force level 0 and stop immediately
//   fan_en     level-sensitive: 0 forces level 0 and stops immediately
//   level      current speed level
//   target     target duty for the current level
//   duty       current ramped duty
//   running    level != 0
//   ramp_busy  duty != target
//   pwm        registered fan PWM output
module fan_pwm_ramp_ctrl #(
  parameter int SYS_FREQ  = 125,
  parameter int N         = 12,
  parameter int LEVELS    = 8,
  parameter int PWM_FREQ  = 200,
  parameter int RAMP_STEP = 64,
  parameter int RAMP_MS   = 1,
  localparam int LW       = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          step,
  input  logic          load,
  input  logic [LW-1:0] level_in,
  input  logic          set_idle,
  input  logic          fan_en,
  output logic [LW-1:0] level,
  output logic [N-1:0]  target,
  output logic [N-1:0]  duty,
  output logic          running,
  output logic          ramp_busy,
  output logic          pwm
);

  localparam int TICK_DIV = SYS_FREQ * 1000 * RAMP_MS;
  localparam int PSW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int P        = (SYS_FREQ * 1_000_000) / PWM_FREQ;
  localparam int CW       = (P > 1) ? $clog2(P) : 1;
  localparam int TW       = LW + N;
  localparam int MW       = N + CW;
  localparam int DW       = N + 1;
  localparam int FULL_I   = (1 << N) - 1;

  localparam logic [N-1:0]  FULL    = '1;
  localparam logic [LW-1:0] LVL_MAX = LW'(LEVELS - 1);

  logic           force_stop;
  logic [LW-1:0]  level_next;
  logic [TW-1:0]  tgt_prod;
  logic [TW-1:0]  tgt_quot;
  logic [PSW-1:0] pre;
  logic           tick;
  logic [DW-1:0]  inc;
  logic [DW-1:0]  dec;
  logic [N-1:0]   duty_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  compare;
  logic [N-1:0]   duty_lat;
  logic [MW-1:0]  cmp_prod;

  assign force_stop = !fan_en | set_idle;
  assign tick       = (pre == PSW'(TICK_DIV - 1));
  assign running    = |level;
  assign ramp_busy  = (duty != target);

  // Floored level * full-scale / (LEVELS-1); the divisor is a constant.
  assign tgt_prod = TW'(level) * TW'(FULL_I);
  assign tgt_quot = tgt_prod / TW'(LEVELS - 1);

  // One extra bit so the ramp cannot wrap at either end; dec[N] flags
  // an underflow below zero.
  assign inc = {1'b0, duty} + DW'(RAMP_STEP);
  assign dec = {1'b0, duty} - DW'(RAMP_STEP);

  assign cmp_prod = MW'(duty) * MW'(P);

  always_comb begin
    level_next = level;
    if (force_stop)
      level_next = '0;
    else if (load)
      level_next = (level_in > LVL_MAX) ? LVL_MAX : level_in;
    else if (step)
      level_next = (level == LVL_MAX) ? '0 : level + LW'(1);
  end

  always_comb begin
    duty_next = duty;
    if (force_stop) begin
      duty_next = '0;
    end else if (tick) begin
      if (duty < target)
        duty_next = (inc > {1'b0, target}) ? target : inc[N-1:0];
      else if (duty > target)
        duty_next = (dec[N] || (dec[N-1:0] < target)) ? target : dec[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level  <= '0;
      target <= '0;
      duty   <= '0;
      pre    <= '0;
    end else begin
      level  <= level_next;
      target <= tgt_quot[N-1:0];
      duty   <= duty_next;
      pre    <= tick ? '0 : pre + PSW'(1);
    end
  end

  // Compare and its source duty are only reloaded at period start so a
  // period is never cut short; emergency stop bypasses that.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      compare  <= '0;
      duty_lat <= '0;
      pwm      <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(P - 1)) ? '0 : cnt + CW'(1);
      pwm <= (duty_lat == FULL) | (cnt < compare);
      if (force_stop) begin
        compare  <= '0;
        duty_lat <= '0;
      end else if (cnt == '0) begin
        compare  <= cmp_prod[MW-1:N];
        duty_lat <= duty;
      end
    end
  end

endmodule
